led_scan_capture: RTL and testbench

Receive-side counterpart of the 8x8 RGB matrix scan driver. It samples the multiplexed row-select and active-low column lines and rebuilds complete frames in an internal buffer. Each valid frame is committed atomically to a readable frame store. The block sits on loopback/debug boards and on secondary display boards fed by the game board's scan outputs.

---
 rtl/led_scan_capture.sv | 159 +++++++++++++++
 tb/tb_led_scan_capture.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_capture.sv
// led_scan_capture: rebuilds 8x8 RGB frames from a row-multiplexed, active-low scan and commits
// each complete frame atomically to a readable frame store.
// Optional feature: define LED_SCAN_CAPTURE_DIFF_EN to build the commit-time frame comparator
// that drives frame_changed; otherwise frame_changed is tied low.
module led_scan_capture #(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [2:0]       row_sel,
  input  logic [7:0]       red_n,
  input  logic [7:0]       grn_n,
  input  logic [7:0]       blu_n,
  input  logic [2:0]       rd_row,
  output logic [7:0]       rd_red,
  output logic [7:0]       rd_grn,
  output logic [7:0]       rd_blu,
  output logic             frame_valid,
  output logic             frame_changed,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked
);
  typedef enum logic {HUNT, FILL} state_t;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);
  state_t           state_q;
  logic [2:0]       row_q, row_prev_q;
  logic [7:0]       red_q, grn_q, blu_q;
  logic [3:0]       stable_q, stable_d;
  logic [6:0]       mask_q;
  logic [7:0]       wk_red_q [8];
  logic [7:0]       wk_grn_q [8];
  logic [7:0]       wk_blu_q [8];
  logic [7:0]       st_red_q [8];
  logic [7:0]       st_grn_q [8];
  logic [7:0]       st_blu_q [8];
  logic [7:0]       rd_red_q, rd_grn_q, rd_blu_q;
  logic             frame_valid_q, frame_changed_q, sync_err_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             chg, legal, cap, last_row, mask_full, hunt_cap, fill_cap, commit, err, diff;

  assign chg       = row_q != row_prev_q;
  assign legal     = row_q == row_prev_q + 3'd1;
  assign stable_d  = chg ? 4'd0 : (stable_q == SETTLE_C ? stable_q : stable_q + 4'd1);
  assign cap       = !chg && stable_d == SETTLE_C && stable_q != SETTLE_C;
  assign last_row  = row_q == 3'd7;
  assign mask_full = &mask_q;
  assign hunt_cap  = state_q == HUNT && cap && row_q == 3'd0;
  assign fill_cap  = state_q == FILL && cap;
  assign commit    = fill_cap && last_row && mask_full;
  assign err       = state_q == FILL && ((chg && !legal) || (cap && last_row && !mask_full));

`ifdef LED_SCAN_CAPTURE_DIFF_EN
  // Compare the frame about to be committed (row 7 still on the input register) with the store
  always_comb begin
    diff = red_q != st_red_q[7] || grn_q != st_grn_q[7] || blu_q != st_blu_q[7];
    for (int i = 0; i < 7; i++)
      diff = diff || wk_red_q[i] != st_red_q[i] || wk_grn_q[i] != st_grn_q[i] || wk_blu_q[i] != st_blu_q[i];
  end
`else
  assign diff = 1'b0;
`endif

  // Register the scan pins once; columns are inverted so a stored 1 means pixel on
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      row_q      <= '0;
      row_prev_q <= '0;
      red_q      <= '0;
      grn_q      <= '0;
      blu_q      <= '0;
    end else begin
      row_q      <= row_sel;
      row_prev_q <= row_q;
      red_q      <= ~red_n;
      grn_q      <= ~grn_n;
      blu_q      <= ~blu_n;
    end
  end

  // Dwell counter: restarts on every row change and parks at SETTLE so each dwell captures once
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) stable_q <= '0;
    else        stable_q <= stable_d;
  end

  // HUNT/FILL sequencer with working buffer, row mask, atomic commit and error accounting
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q         <= HUNT;
      mask_q          <= '0;
      err_cnt_q       <= '0;
      frame_valid_q   <= 1'b0;
      frame_changed_q <= 1'b0;
      sync_err_q      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        wk_red_q[i] <= '0;
        wk_grn_q[i] <= '0;
        wk_blu_q[i] <= '0;
        st_red_q[i] <= '0;
        st_grn_q[i] <= '0;
        st_blu_q[i] <= '0;
      end
    end else begin
      frame_valid_q   <= commit;
      frame_changed_q <= commit && diff;
      sync_err_q      <= err;
      if (err) begin
        state_q <= HUNT;
        mask_q  <= '0;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
      end else if (hunt_cap) begin
        state_q     <= FILL;
        mask_q      <= 7'b0000001;
        wk_red_q[0] <= red_q;
        wk_grn_q[0] <= grn_q;
        wk_blu_q[0] <= blu_q;
      end else if (commit) begin
        mask_q <= '0;
        for (int i = 0; i < 7; i++) begin
          st_red_q[i] <= wk_red_q[i];
          st_grn_q[i] <= wk_grn_q[i];
          st_blu_q[i] <= wk_blu_q[i];
        end
        st_red_q[7] <= red_q;
        st_grn_q[7] <= grn_q;
        st_blu_q[7] <= blu_q;
      end else if (fill_cap) begin
        mask_q          <= mask_q | 7'(8'b1 << row_q);
        wk_red_q[row_q] <= red_q;
        wk_grn_q[row_q] <= grn_q;
        wk_blu_q[row_q] <= blu_q;
      end
    end
  end

  // Registered frame-store read port
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_red_q <= '0;
      rd_grn_q <= '0;
      rd_blu_q <= '0;
    end else begin
      rd_red_q <= st_red_q[rd_row];
      rd_grn_q <= st_grn_q[rd_row];
      rd_blu_q <= st_blu_q[rd_row];
    end
  end

  assign rd_red        = rd_red_q;
  assign rd_grn        = rd_grn_q;
  assign rd_blu        = rd_blu_q;
  assign frame_valid   = frame_valid_q;
  assign frame_changed = frame_changed_q;
  assign sync_err      = sync_err_q;
  assign err_cnt       = err_cnt_q;
  assign locked        = state_q == FILL;
endmodule

// File: tb/tb_led_scan_capture.sv
// tb_led_scan_capture: directed scan scenarios with a commit scoreboard for led_scan_capture
module tb_led_scan_capture;
  logic       CLK = 1'b0, RST_N = 1'b0;
  logic [2:0] row_sel = 3'd7, rd_row = 3'd0;
  logic [7:0] red_n = 8'hFF, grn_n = 8'hFF, blu_n = 8'hFF;
  logic [7:0] rd_red, rd_grn, rd_blu, err_cnt;
  logic       frame_valid, frame_changed, sync_err, locked;
  int         vec = 0, fails = 0, serr_seen = 0, fv_seen = 0, fv0 = 0;
  logic       exp_q [$];
  logic [7:0] fr_r [8], fr_g [8], fr_b [8], ms_r [8], ms_g [8], ms_b [8];
`ifdef LED_SCAN_CAPTURE_DIFF_EN
  localparam bit DIFF_EN = 1'b1;
`else
  localparam bit DIFF_EN = 1'b0;
`endif

  led_scan_capture #(.SETTLE(2), .ERR_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .row_sel(row_sel), .red_n(red_n), .grn_n(grn_n), .blu_n(blu_n),
    .rd_row(rd_row), .rd_red(rd_red), .rd_grn(rd_grn), .rd_blu(rd_blu),
    .frame_valid(frame_valid), .frame_changed(frame_changed), .sync_err(sync_err),
    .err_cnt(err_cnt), .locked(locked)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    if (sync_err === 1'b1) serr_seen++;
    if (frame_valid === 1'b1) begin
      fv_seen++;
      chk("commit_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("frame_changed", frame_changed, exp_q.pop_front());
    end else if (frame_changed !== 1'b0) chk("changed_without_valid", frame_changed, 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_rd_red", rd_red, 0);
    chk("rst_rd_grn", rd_grn, 0);
    chk("rst_rd_blu", rd_blu, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_changed", frame_changed, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_locked", locked, 0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    row_sel = 3'd7;
    red_n = 8'hFF;
    grn_n = 8'hFF;
    blu_n = 8'hFF;
    #1;
    chk_reset_outs();
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      ms_r[i] = '0;
      ms_g[i] = '0;
      ms_b[i] = '0;
    end
    exp_q.delete();
    RST_N = 1'b1;
    repeat (3) tick();
  endtask

  task automatic set_frame(input int seed);
    for (int i = 0; i < 8; i++) begin
      fr_r[i] = 8'(seed * 29 + i * 7 + 3);
      fr_g[i] = 8'(seed * 53 + i * 13 + 1);
      fr_b[i] = 8'(seed * 71 + i * 5 + 9);
    end
  endtask

  task automatic scan_row(input int r, input int n);
    row_sel = 3'(r);
    red_n = ~fr_r[r];
    grn_n = ~fr_g[r];
    blu_n = ~fr_b[r];
    repeat (n) tick();
  endtask

  task automatic send_frame(input bit commit, input int row0_len, input int dwell, input int short_row);
    bit d;
    d = 1'b0;
    if (commit) begin
      for (int i = 0; i < 8; i++)
        if (fr_r[i] != ms_r[i] || fr_g[i] != ms_g[i] || fr_b[i] != ms_b[i]) d = 1'b1;
      exp_q.push_back(DIFF_EN && d);
      for (int i = 0; i < 8; i++) begin
        ms_r[i] = fr_r[i];
        ms_g[i] = fr_g[i];
        ms_b[i] = fr_b[i];
      end
    end
    for (int r = 0; r < 8; r++) scan_row(r, r == short_row ? 1 : (r == 0 ? row0_len : dwell));
  endtask

  task automatic drain();
    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic read_check();
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      tick();
      chk($sformatf("rd_red[%0d]", r), rd_red, ms_r[r]);
      chk($sformatf("rd_grn[%0d]", r), rd_grn, ms_g[r]);
      chk($sformatf("rd_blu[%0d]", r), rd_blu, ms_b[r]);
    end
  endtask

  initial begin
    do_reset();
    // single red pixel on row 2
    for (int i = 0; i < 8; i++) begin
      fr_r[i] = '0;
      fr_g[i] = '0;
      fr_b[i] = '0;
    end
    fr_r[2] = 8'h01;
    send_frame(1'b1, 4, 4, -1);
    drain();
    chk("first_commit_count", fv_seen, 1);
    chk("locked_after_commit", locked, 1);
    read_check();
    // driver-style 9-step scan, row 0 held double length
    fv0 = fv_seen;
    for (int k = 1; k <= 3; k++) begin
      set_frame(k);
      send_frame(1'b1, 8, 4, -1);
    end
    drain();
    chk("nine_step_commits", fv_seen - fv0, 3);
    chk("nine_step_err_cnt", err_cnt, 0);
    chk("nine_step_sync_err", serr_seen, 0);
    read_check();
    // illegal jump 2 -> 5, then recovery
    set_frame(7);
    scan_row(0, 4);
    scan_row(1, 4);
    scan_row(2, 4);
    scan_row(5, 4);
    scan_row(6, 4);
    scan_row(7, 4);
    repeat (2) tick();
    chk("jump_sync_err", serr_seen, 1);
    chk("jump_err_cnt", err_cnt, 1);
    chk("jump_locked", locked, 0);
    chk("jump_no_commit", exp_q.size(), 0);
    send_frame(1'b1, 4, 4, -1);
    drain();
    chk("recover_locked", locked, 1);
    read_check();
    // row 4 dwell shorter than SETTLE leaves the mask incomplete
    do_reset();
    serr_seen = 0;
    set_frame(9);
    send_frame(1'b0, 4, 4, 4);
    repeat (4) tick();
    chk("short_sync_err", serr_seen, 1);
    chk("short_err_cnt", err_cnt, 1);
    chk("short_locked", locked, 0);
    read_check();
    // reset in the middle of a differing frame
    set_frame(11);
    send_frame(1'b1, 4, 4, -1);
    drain();
    read_check();
    set_frame(12);
    for (int r = 0; r < 5; r++) scan_row(r, 4);
    scan_row(5, 2);
    do_reset();
    chk("post_reset_locked", locked, 0);
    read_check();
    repeat (10) tick();
    set_frame(13);
    send_frame(1'b1, 4, 4, -1);
    drain();
    read_check();
    // two identical frames then one blue pixel change on row 7
    set_frame(20);
    fr_b[7] = fr_b[7] & ~8'h08;
    send_frame(1'b1, 4, 4, -1);
    send_frame(1'b1, 4, 4, -1);
    fr_b[7] = fr_b[7] | 8'h08;
    send_frame(1'b1, 4, 4, -1);
    drain();
    read_check();
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule
